// File: rtl/csr_unit_if.sv
// CSR access bus between the MEM stage and the CSR unit.
//   csr_valid  : CSR instruction present this cycle
//   csr_op     : funct3 of the instruction
//   csr_addr   : 12-bit CSR address
//   rs1_val    : forwarded rs1 operand (register forms)
//   rs1_zimm   : rs1 field; zimm for immediate forms
//   csr_rdata  : old CSR value for the write-back mux (combinational)
//   illegal    : illegal CSR access (combinational)
interface csr_unit_if #(
  parameter int XLEN = 32
);
  logic            csr_valid;
  logic [2:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] rs1_val;
  logic [4:0]      rs1_zimm;
  logic [XLEN-1:0] csr_rdata;
  logic            illegal;

  modport master (
    output csr_valid, csr_op, csr_addr, rs1_val, rs1_zimm,
    input  csr_rdata, illegal
  );

  modport slave (
    input  csr_valid, csr_op, csr_addr, rs1_val, rs1_zimm,
    output csr_rdata, illegal
  );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file: Zicsr read-modify-write, trap entry, mret and
// 64-bit mcycle/minstret counters. Lives in MEM; returns the pre-write CSR
// value and registers a one-cycle PC redirect for fetch.
// Ports:
//   clk, rst_n      : clock (rising edge), async active-low reset
//   bus (slave)     : CSR access request/response (see csr_unit_if)
//   stall           : gates CSR writes, mret and retire (not traps)
//   retire          : one instruction retires this cycle
//   trap_req/cause/pc/val : trap entry request and its state
//   mret            : mret in this stage
//   redirect_valid/pc : registered redirect pulse and target
//   irq_enable      : mstatus.MIE
// XLEN must be 32 or 64.
module csr_unit #(
  parameter int          XLEN        = 32,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter int unsigned HART_ID     = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  csr_unit_if.slave       bus,
  input  logic            stall,
  input  logic            retire,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_val,
  input  logic            mret,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            irq_enable
);

  localparam bit IS32 = (XLEN == 32);

  // architectural state
  logic            st_mie, st_mpie;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0]     mcycle_q, minstret_q;

  logic [XLEN-1:0] src, old_val, new_val, mstatus_rd, mtvec_rd;
  logic            known, bad_op, wr_supp, illegal, wr_fire;
  logic [63:0]     mcycle_nxt, minstret_nxt;
  logic [XLEN-1:0] trap_base, trap_off, trap_tgt;

  assign irq_enable = st_mie;

  // MPP is hardwired to M-mode; only MIE/MPIE are storage.
  always_comb begin
    mstatus_rd     = '0;
    mstatus_rd[12] = 1'b1;
    mstatus_rd[11] = 1'b1;
    mstatus_rd[7]  = st_mpie;
    mstatus_rd[3]  = st_mie;
  end

  assign mtvec_rd = {mtvec_q[XLEN-1:2], 1'b0, mtvec_q[0]};

  // ---- read decode ----
  always_comb begin
    old_val = '0;
    known   = 1'b1;
    case (bus.csr_addr)
      12'h300: old_val = mstatus_rd;
      12'h301: old_val = '0;
      12'h304: old_val = mie_q;
      12'h305: old_val = mtvec_rd;
      12'h340: old_val = mscratch_q;
      12'h341: old_val = mepc_q;
      12'h342: old_val = mcause_q;
      12'h343: old_val = mtval_q;
      12'hB00, 12'hC00: old_val = XLEN'(mcycle_q);
      12'hB02, 12'hC02: old_val = XLEN'(minstret_q);
      12'hB80, 12'hC80: if (IS32) old_val = XLEN'(mcycle_q[63:32]);   else known = 1'b0;
      12'hB82, 12'hC82: if (IS32) old_val = XLEN'(minstret_q[63:32]); else known = 1'b0;
      12'hF14: old_val = XLEN'(HART_ID);
      default: known = 1'b0;
    endcase
  end

  // ---- op / legality ----
  assign src     = bus.csr_op[2] ? XLEN'(bus.rs1_zimm) : bus.rs1_val;
  assign bad_op  = (bus.csr_op[1:0] == 2'b00);
  // RS/RC with a zero source are pure reads, which keeps read-only CSRs legal.
  assign wr_supp = (bus.csr_op[1:0] != 2'b01) && (bus.rs1_zimm == 5'd0);
  assign illegal = bus.csr_valid &
                   (bad_op | ~known | ((bus.csr_addr[11:10] == 2'b11) & ~wr_supp));

  always_comb begin
    case (bus.csr_op[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = old_val;
    endcase
  end

  assign bus.csr_rdata = illegal ? '0 : old_val;
  assign bus.illegal   = illegal;

  // trap and mret outrank an ordinary CSR write in the same cycle
  assign wr_fire = bus.csr_valid & ~stall & ~illegal & ~wr_supp & ~trap_req & ~mret;

  // ---- counters: a write to either half replaces that cycle's increment ----
  always_comb begin
    mcycle_nxt = mcycle_q + 64'd1;
    if (wr_fire && bus.csr_addr == 12'hB00)
      mcycle_nxt = IS32 ? {mcycle_q[63:32], new_val[31:0]} : 64'(new_val);
    if (wr_fire && bus.csr_addr == 12'hB80)
      mcycle_nxt = {new_val[31:0], mcycle_q[31:0]};
  end

  always_comb begin
    minstret_nxt = minstret_q + {63'd0, retire & ~stall};
    if (wr_fire && bus.csr_addr == 12'hB02)
      minstret_nxt = IS32 ? {minstret_q[63:32], new_val[31:0]} : 64'(new_val);
    if (wr_fire && bus.csr_addr == 12'hB82)
      minstret_nxt = {new_val[31:0], minstret_q[31:0]};
  end

  // ---- trap target: vectored only for interrupts when mtvec.MODE=1 ----
  assign trap_base = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_off  = XLEN'({trap_cause[XLEN-2:0], 2'b00});
  assign trap_tgt  = trap_base + ((mtvec_q[0] & trap_cause[XLEN-1]) ? trap_off : '0);

  // ---- state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie         <= 1'b0;
      st_mpie        <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= XLEN'(MTVEC_RESET);
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      mcycle_q       <= mcycle_nxt;
      minstret_q     <= minstret_nxt;
      redirect_valid <= 1'b0;
      if (trap_req) begin
        mepc_q         <= trap_pc & ~XLEN'(3);
        mcause_q       <= trap_cause;
        mtval_q        <= trap_val;
        st_mpie        <= st_mie;
        st_mie         <= 1'b0;
        redirect_valid <= 1'b1;
        redirect_pc    <= trap_tgt;
      end else if (mret && !stall) begin
        st_mie         <= st_mpie;
        st_mpie        <= 1'b1;
        redirect_valid <= 1'b1;
        redirect_pc    <= mepc_q;
      end else if (wr_fire) begin
        case (bus.csr_addr)
          12'h300: begin
            st_mie  <= new_val[3];
            st_mpie <= new_val[7];
          end
          12'h304: mie_q      <= new_val;
          12'h305: mtvec_q    <= new_val;
          12'h340: mscratch_q <= new_val;
          12'h341: mepc_q     <= new_val & ~XLEN'(3);
          12'h342: mcause_q   <= new_val;
          12'h343: mtval_q    <= new_val;
          default: ;
        endcase
      end
    end
  end

endmodule
